// File: rtl/uart_tx_arb_if.sv
// Requester byte streams and the uart_tx start/busy handshake shared by the arbiter.
// The master side is the environment (requesters plus serializer); the slave side is the arbiter.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one uart_tx serializer, one byte per frame.
// A grant is held until the last byte has left the line, or revoked after a mid-packet stall.
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_arb_if.slave    bus,
    output logic            grant_active,
    output logic [ID_W-1:0] grant_id,
    output logic            timeout_err
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_active_q, grant_active_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]   pick;
    logic              pick_found;
    logic [ID_W-1:0]   idx;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Scanning from the farthest offset down lets the requester closest to rr_ptr win.
    always_comb begin
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        idx        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = rr_index(rr_ptr_q, i);
            if (bus.req_valid[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // NOTE: every next-state variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        timeout_err_d  = 1'b0;

        case (state_q)
            ARB: begin
                if (!bus.tx_busy && pick_found) begin
                    grant_id_d     = pick;
                    grant_active_d = 1'b1;
                    state_d        = FETCH;
                end
            end
            FETCH: begin
                if (bus.req_valid[grant_id_q]) begin
                    tx_data_d = bus.req_data[8*grant_id_q +: 8];
                    last_d    = bus.req_last[grant_id_q];
                    cnt_d     = '0;
                    state_d   = SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d  = 1'b1;
                    grant_active_d = 1'b0;
                    rr_ptr_d       = rr_index(grant_id_q, 1);
                    cnt_d          = '0;
                    state_d        = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                // uart_tx raises tx_busy from tx_valid, so WAIT always lasts at least one cycle.
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = rr_index(grant_id_q, 1);
                        state_d        = ARB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Handshake outputs decode only the state register and the held grant, keeping tx_busy off the tx_valid path.
    assign bus.req_ready = (state_q == FETCH) ? (N_REQ'(1) << grant_id_q) : '0;
    assign bus.tx_valid  = (state_q == SEND);
    assign bus.tx_data   = tx_data_q;
    assign grant_active  = grant_active_q;
    assign grant_id      = grant_id_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural uart_tx, queue-based requesters and a line decoder.
module tb_uart_tx_arb;
    localparam int N       = 4;
    localparam int BIT_CYC = 4;
    localparam int TO      = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       grant_active;
    logic [1:0] grant_id;
    logic       timeout_err;

    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_REQ(N)) bus ();

    uart_tx_arb #(.N_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Requesters: per-requester byte queues {last, data}, presented while enabled and non-empty.
    logic [8:0]   mem [N][64];
    int           head [N];
    int           tail [N];
    logic [N-1:0] en;
    logic [N-1:0] v_vec, l_vec;
    logic [8*N-1:0] d_vec;

    always_comb begin
        v_vec = '0;
        l_vec = '0;
        d_vec = '0;
        for (int i = 0; i < N; i++) begin
            v_vec[i]       = en[i] && (head[i] != tail[i]);
            d_vec[8*i +: 8] = mem[i][head[i]][7:0];
            l_vec[i]       = v_vec[i] && mem[i][head[i]][8];
        end
    end

    assign bus.req_valid = v_vec;
    assign bus.req_data  = d_vec;
    assign bus.req_last  = l_vec;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    always @(posedge clk) begin
        logic [N-1:0] acc;
        acc = bus.req_ready & bus.req_valid & {N{~rst}};
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
    end

    // Behavioural uart_tx: 10-bit frame, BIT_CYC clocks per bit, busy derived combinationally from tx_valid.
    logic       busy_q;
    logic [9:0] sh;
    int         bitn, div;
    logic       tx_line;

    assign bus.tx_busy = bus.tx_valid | busy_q;
    assign tx_line     = busy_q ? sh[bitn] : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            bitn   <= 0;
            div    <= 0;
        end else if (!busy_q && bus.tx_valid) begin
            sh     <= {1'b1, bus.tx_data, 1'b0};
            busy_q <= 1'b1;
            bitn   <= 0;
            div    <= 0;
        end else if (busy_q) begin
            if (div == BIT_CYC - 1) begin
                div <= 0;
                if (bitn == 9) busy_q <= 1'b0;
                else bitn <= bitn + 1;
            end else begin
                div <= div + 1;
            end
        end
    end

    // Line decoder: sample each bit near its centre after the start edge.
    logic [7:0] rx_dat [32];
    int         rx_n = 0;
    logic       rx_st = 1'b0;
    int         rx_cnt;
    logic [7:0] rx_sh;
    int         stop_bad = 0;

    always @(posedge clk) begin
        if (rst) begin
            rx_st = 1'b0;
        end else if (!rx_st) begin
            if (!tx_line) begin
                rx_st  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 4*9 + 1) begin
                if (!tx_line) stop_bad++;
                if (rx_n < 32) rx_dat[rx_n] = rx_sh;
                rx_n++;
                rx_st = 1'b0;
            end else if (rx_cnt >= 5 && ((rx_cnt - 1) % 4) == 0) begin
                rx_sh = {tx_line, rx_sh[7:1]};
            end
        end
    end

    // Protocol monitor sampled on the falling edge.
    logic [7:0] log_dat [32];
    logic [1:0] log_id  [32];
    int   log_n = 0;
    int   pulse_bad = 0, busy_bad = 0, gap_bad = 0, ready_bad = 0, to_ga_bad = 0;
    int   to_cnt = 0, to_run = 0, run = 0, idle_run = 100;
    logic prev_tv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_tv  = 1'b0;
            idle_run = 100;
            run      = 0;
        end else begin
            if (bus.tx_valid) begin
                if (log_n < 32) begin
                    log_dat[log_n] = bus.tx_data;
                    log_id[log_n]  = grant_id;
                end
                log_n++;
                if (prev_tv) pulse_bad++;
                if (busy_q) busy_bad++;
                if (idle_run < 2) gap_bad++;
            end
            if (busy_q || bus.tx_valid) idle_run = 0;
            else idle_run++;
            if ($countones(bus.req_ready) > 1) ready_bad++;
            if (timeout_err) begin
                to_cnt++;
                to_run = run;
                if (grant_active || (|bus.req_ready)) to_ga_bad++;
            end
            if (|bus.req_ready) run++;
            else run = 0;
            prev_tv = bus.tx_valid;
        end
    end

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while ((log_n < n || grant_active || busy_q || rx_st) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", 32'(k < 3000), 1);
    endtask

    int         exp_id  [20] = '{0,1,2,3,0,1,2,3, 2,2, 0,0,0,1,1,1, 3,0, 1,1};
    logic [7:0] exp_dat [20] = '{8'hA0,8'hA1,8'hA2,8'hA3,8'hB0,8'hB1,8'hB2,8'hB3,
                                 8'h55,8'hA3, 8'h11,8'h12,8'h13,8'h21,8'h22,8'h23,
                                 8'h10,8'h77, 8'h01,8'h02};

    initial begin
        int k;
        int j;
        rst = 1'b1;
        en  = '0;
        // Reset with all requesters valid, then two single-byte packets each.
        for (int i = 0; i < N; i++) begin
            push(i, 8'hA0 + 8'(i), 1'b1);
            push(i, 8'hB0 + 8'(i), 1'b1);
        end
        en = '1;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(bus.req_ready), 0);
        check("rst_txv",    32'(bus.tx_valid), 0);
        check("rst_ga",     32'(grant_active), 0);
        check("rst_gid",    32'(grant_id), 0);
        check("rst_to",     32'(timeout_err), 0);
        check("rst_txdata", 32'(bus.tx_data), 0);
        rst = 1'b0;
        wait_tx(8);

        // Lone requester 2, two-byte packet.
        push(2, 8'h55, 1'b0);
        push(2, 8'hA3, 1'b1);
        wait_tx(10);
        check("t2_ga",  32'(grant_active), 0);
        check("t2_gid", 32'(grant_id), 2);

        // Requesters 0 and 1 contend with 3-byte packets.
        push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
        push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
        wait_tx(16);

        // Requester 3 stalls mid-packet; requester 0 waits.
        push(3, 8'h10, 1'b0);
        push(0, 8'h77, 1'b1);
        wait_tx(18);
        check("t5_to_cnt", 32'(to_cnt), 1);
        check("t5_to_run", 32'(to_run), TO);

        // Reset while the first byte of a two-byte packet is on the line.
        push(1, 8'h01, 1'b0);
        push(1, 8'h02, 1'b1);
        k = 0;
        while (log_n < 19 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t6_first", 32'(k < 500), 1);
        repeat (10) @(negedge clk);
        rst   = 1'b1;
        en[1] = 1'b0;
        @(negedge clk);
        check("t6_txv",  32'(bus.tx_valid), 0);
        check("t6_rdy",  32'(bus.req_ready), 0);
        check("t6_ga",   32'(grant_active), 0);
        check("t6_gid",  32'(grant_id), 0);
        check("t6_to",   32'(timeout_err), 0);
        check("t6_line", 32'(tx_line), 1);
        check("t6_data", 32'(bus.tx_data), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t6_quiet", 32'(log_n), 19);
        check("t6_line_idle", 32'(tx_line), 1);
        en[1] = 1'b1;
        wait_tx(20);

        check("log_n", 32'(log_n), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("tx_id[%0d]", i),  32'(log_id[i]),  32'(exp_id[i]));
            check($sformatf("tx_dat[%0d]", i), 32'(log_dat[i]), 32'(exp_dat[i]));
        end
        check("rx_n", 32'(rx_n), 19);
        j = 0;
        for (int i = 0; i < 20; i++) begin
            if (i != 18) begin
                check($sformatf("rx_dat[%0d]", j), 32'(rx_dat[j]), 32'(exp_dat[i]));
                j++;
            end
        end
        check("pulse_width", 32'(pulse_bad), 0);
        check("tx_while_busy", 32'(busy_bad), 0);
        check("line_gap", 32'(gap_bad), 0);
        check("ready_onehot", 32'(ready_bad), 0);
        check("to_vs_grant", 32'(to_ga_bad), 0);
        check("stop_bits", 32'(stop_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
